// File: rtl/hart_pkg.sv
// Shared types and constants for the heart-rate meter.
// Used by hart_rate_meter and its beat_edge_sync front end.
package hart_pkg;

  localparam int unsigned HART_W     = 6;
  localparam int unsigned HART_MAX   = 63;
  localparam int unsigned BEAT_CNT_W = 8;

  typedef enum logic {
    StStart,
    StMeasure
  } hart_state_e;

  // Clamp a raw window count to the published 6-bit range.
  function automatic logic [HART_W-1:0] sat_hart(input logic [BEAT_CNT_W-1:0] cnt);
    if (cnt > BEAT_CNT_W'(HART_MAX)) begin
      return HART_W'(HART_MAX);
    end
    return cnt[HART_W-1:0];
  endfunction

endpackage

// File: rtl/beat_edge_sync.sv
// Beat front end: 2-flop synchronizer, registered rising-edge detect and
// a refractory counter that masks edges for REFRACT_TICKS after each accepted one.
module beat_edge_sync #(
  parameter int unsigned REFRACT_TICKS = 2
) (
  input  logic slow,
  input  logic reset,
  input  logic beat,
  output logic beat_acc
);

  logic       sync1_q, sync2_q, prev_q;
  logic       acc_q, acc_d;
  logic [3:0] refr_q, refr_d;
  logic       rise;

  always_comb begin
    rise   = sync2_q & ~prev_q;
    acc_d  = rise && (refr_q == 4'd0);
    refr_d = refr_q;
    if (acc_d) begin
      refr_d = 4'(REFRACT_TICKS);
    end else if (refr_q != 4'd0) begin
      refr_d = refr_q - 4'd1;
    end
  end

  always_ff @(posedge slow or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      acc_q   <= 1'b0;
      refr_q  <= 4'd0;
    end else begin
      sync1_q <= beat;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      acc_q   <= acc_d;
      refr_q  <= refr_d;
    end
  end

  assign beat_acc = acc_q;

endmodule

// File: rtl/hart_rate_meter.sv
// Heart-rate meter: counts accepted beats per WINDOW_TICKS window and publishes a
// saturated 6-bit rate with a one-tick strobe. Define HART_AVG_EN to average with prior window.
module hart_rate_meter
  import hart_pkg::*;
#(
  parameter int unsigned WINDOW_TICKS  = 60,
  parameter int unsigned REFRACT_TICKS = 2
) (
  input  logic              slow,
  input  logic              reset,
  input  logic              beat,
  output logic [HART_W-1:0] hart,
  output logic              hart_valid,
  output logic              overflow,
  output logic              flatline
);

  localparam int unsigned WinW = (WINDOW_TICKS > 1) ? $clog2(WINDOW_TICKS) : 1;
  localparam logic [WinW-1:0] WinLast = WinW'(WINDOW_TICKS - 1);

  logic beat_acc;

  beat_edge_sync #(
    .REFRACT_TICKS(REFRACT_TICKS)
  ) u_beat_edge_sync (
    .slow    (slow),
    .reset   (reset),
    .beat    (beat),
    .beat_acc(beat_acc)
  );

  hart_state_e           state_q, state_d;
  logic [WinW-1:0]       win_q, win_d;
  logic [BEAT_CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [HART_W-1:0]     hart_q, hart_d, cur, pub;
  logic                  valid_q, valid_d;
  logic                  ovf_q, ovf_d;
  logic                  flat_q, flat_d;

`ifdef HART_AVG_EN
  logic [HART_W-1:0] prev_q, prev_d;
  logic              first_q, first_d;
  logic [HART_W:0]   avg_sum;

  always_comb begin
    avg_sum = {1'b0, cur} + {1'b0, prev_q} + 7'd1;
    pub     = first_q ? cur : avg_sum[HART_W:1];
  end
`else
  assign pub = cur;
`endif

  // Count including an edge accepted this tick; saturates at the counter width.
  always_comb begin
    cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + BEAT_CNT_W'(beat_acc);
    cur     = sat_hart(cnt_inc);
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    hart_d  = hart_q;
    valid_d = 1'b0;
    ovf_d   = ovf_q;
    flat_d  = flat_q;
`ifdef HART_AVG_EN
    prev_d  = prev_q;
    first_d = first_q;
`endif
    unique case (state_q)
      StStart: begin
        win_d = '0;
        cnt_d = '0;
        if (beat_acc) begin
          cnt_d   = BEAT_CNT_W'(1);
          flat_d  = 1'b0;
          state_d = StMeasure;
        end
      end
      StMeasure: begin
        if (win_q == WinLast) begin
          valid_d = 1'b1;
          win_d   = '0;
          cnt_d   = '0;
          ovf_d   = (cnt_inc > BEAT_CNT_W'(HART_MAX));
          if (cnt_inc == '0) begin
            hart_d  = '0;
            flat_d  = 1'b1;
            state_d = StStart;
`ifdef HART_AVG_EN
            prev_d  = '0;
            first_d = 1'b1;
`endif
          end else begin
            hart_d = pub;
`ifdef HART_AVG_EN
            prev_d  = cur;
            first_d = 1'b0;
`endif
          end
        end else begin
          win_d = win_q + WinW'(1);
          cnt_d = cnt_inc;
        end
      end
    endcase
  end

  always_ff @(posedge slow or posedge reset) begin
    if (reset) begin
      state_q <= StStart;
      win_q   <= '0;
      cnt_q   <= '0;
      hart_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      flat_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      hart_q  <= hart_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      flat_q  <= flat_d;
    end
  end

`ifdef HART_AVG_EN
  always_ff @(posedge slow or posedge reset) begin
    if (reset) begin
      prev_q  <= '0;
      first_q <= 1'b1;
    end else begin
      prev_q  <= prev_d;
      first_q <= first_d;
    end
  end
`endif

  assign hart       = hart_q;
  assign hart_valid = valid_q;
  assign overflow   = ovf_q;
  assign flatline   = flat_q;

endmodule

// File: tb/tb_hart_rate_meter.sv
// Directed self-checking bench for hart_rate_meter (W=60/R=2 and W=240/R=0 instances).
module tb_hart_rate_meter;

  logic       slow = 1'b0;
  logic       rst1 = 1'b0, rst2 = 1'b0;
  logic       beat1 = 1'b0, beat2 = 1'b0;
  logic [5:0] hart1, hart2;
  logic       hv1, hv2, ov1, ov2, fl1, fl2;

  always #5 slow = ~slow;

  hart_rate_meter #(
    .WINDOW_TICKS (60),
    .REFRACT_TICKS(2)
  ) dut1 (
    .slow      (slow),
    .reset     (rst1),
    .beat      (beat1),
    .hart      (hart1),
    .hart_valid(hv1),
    .overflow  (ov1),
    .flatline  (fl1)
  );

  hart_rate_meter #(
    .WINDOW_TICKS (240),
    .REFRACT_TICKS(0)
  ) dut2 (
    .slow      (slow),
    .reset     (rst2),
    .beat      (beat2),
    .hart      (hart2),
    .hart_valid(hv2),
    .overflow  (ov2),
    .flatline  (fl2)
  );

`ifdef HART_AVG_EN
  localparam bit AvgEn = 1'b1;
`else
  localparam bit AvgEn = 1'b0;
`endif

  typedef struct {
    int tk;
    int hart;
    int ov;
    int flat;
  } ev_t;

  ev_t ev1[$];
  ev_t ev2[$];
  int  n_checks = 0;
  int  n_fails = 0;
  int  tk1 = 0;
  int  tk2 = 0;
  int  stable_err = 0;
  int  base;

  function automatic int avg_pub(input int cur, input int prev, input bit first);
    if (!AvgEn || first) return cur;
    return (cur + prev + 1) >> 1;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Beat is high for one tick whenever (k+phase)%period==0; period 0 keeps it low.
  task automatic run1(input int n, input int period, input int phase);
    int last_h;
    for (int k = 0; k < n; k++) begin
      beat1  = (period > 0) && (((k + phase) % period) == 0);
      last_h = int'(hart1);
      @(negedge slow);
      tk1++;
      if (hv1) ev1.push_back('{tk1, int'(hart1), int'(ov1), int'(fl1)});
      else if (int'(hart1) != last_h) stable_err++;
    end
    beat1 = 1'b0;
  endtask

  task automatic run2(input int n, input int period, input int phase);
    for (int k = 0; k < n; k++) begin
      beat2 = (period > 0) && (((k + phase) % period) == 0);
      @(negedge slow);
      tk2++;
      if (hv2) ev2.push_back('{tk2, int'(hart2), int'(ov2), int'(fl2)});
    end
    beat2 = 1'b0;
  endtask

  initial begin
    #1;
    rst1 = 1'b1;
    rst2 = 1'b1;
    repeat (3) @(negedge slow);
    check("rst_hart", int'(hart1), 0);
    check("rst_valid", int'(hv1), 0);
    check("rst_overflow", int'(ov1), 0);
    check("rst_flatline", int'(fl1), 1);
    rst1 = 1'b0;
    rst2 = 1'b0;

    // Idle input: stays in START, nothing published.
    run1(200, 0, 0);
    check("idle_no_valid", ev1.size(), 0);
    check("idle_hart", int'(hart1), 0);
    check("idle_flatline", int'(fl1), 1);

    // One beat per 10 ticks. The first window also holds the entry beat, so it sees 7.
    base = tk1;
    run1(190, 10, 0);
    check("p10_count", ev1.size(), 3);
    check("p10_latency", ev1[0].tk - base, 64);
    check("p10_period_a", ev1[1].tk - ev1[0].tk, 60);
    check("p10_period_b", ev1[2].tk - ev1[1].tk, 60);
    check("p10_hart0", ev1[0].hart, avg_pub(7, 0, 1'b1));
    check("p10_hart1", ev1[1].hart, avg_pub(6, 7, 1'b0));
    check("p10_hart2", ev1[2].hart, avg_pub(6, 6, 1'b0));
    check("p10_overflow", ev1[1].ov, 0);
    check("p10_flatline", ev1[1].flat, 0);

    // Beats stop: a zero window publishes 0 and raises flatline.
    ev1.delete();
    base = tk1;
    run1(70, 0, 0);
    check("flat_count", ev1.size(), 1);
    check("flat_time", ev1[0].tk - base, 54);
    check("flat_hart", ev1[0].hart, 0);
    check("flat_overflow", ev1[0].ov, 0);
    check("flat_flag", ev1[0].flat, 1);
    ev1.delete();
    run1(100, 0, 0);
    check("flat_idle_no_valid", ev1.size(), 0);
    check("flat_idle_flag", int'(fl1), 1);

    // A single beat re-arms; its window publishes unaveraged 1.
    base = tk1;
    run1(4, 1000, 0);
    check("rearm_flatline", int'(fl1), 0);
    run1(60, 0, 0);
    check("rearm_count", ev1.size(), 1);
    check("rearm_time", ev1[0].tk - base, 64);
    check("rearm_hart", ev1[0].hart, 1);

    // Edges every 2 ticks, refractory 2: accepted every 4.
    rst1 = 1'b1;
    @(negedge slow);
    rst1 = 1'b0;
    ev1.delete();
    base = tk1;
    run1(215, 2, 0);
    check("p2_count", ev1.size(), 3);
    check("p2_hart0", ev1[0].hart, avg_pub(16, 0, 1'b1));
    check("p2_hart1", ev1[1].hart, avg_pub(15, 16, 1'b0));
    check("p2_hart2", ev1[2].hart, avg_pub(15, 15, 1'b0));
    check("p2_period", ev1[2].tk - ev1[1].tk, 60);

    // Reset mid-window drops the partial count immediately.
    ev1.delete();
    rst1 = 1'b1;
    #1;
    check("midrst_hart", int'(hart1), 0);
    check("midrst_flatline", int'(fl1), 1);
    check("midrst_valid", int'(hv1), 0);
    @(negedge slow);
    rst1 = 1'b0;
    run1(150, 0, 0);
    check("midrst_no_valid", ev1.size(), 0);
    check("midrst_hart_held", int'(hart1), 0);
    check("hart_stable", stable_err, 0);

    // Long window, no refractory: raw 120 saturates, then 30 per window.
    base = tk2;
    run2(240, 2, 0);
    run2(480, 8, 4);
    check("sat_count", ev2.size(), 2);
    check("sat_time", ev2[0].tk - base, 244);
    check("sat_hart", ev2[0].hart, 63);
    check("sat_overflow", ev2[0].ov, 1);
    check("slow_time", ev2[1].tk - base, 484);
    check("slow_hart", ev2[1].hart, avg_pub(30, 63, 1'b0));
    check("slow_overflow", ev2[1].ov, 0);
    check("slow_flatline", ev2[1].flat, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/hart_rate_meter.md
Name: hart_rate_meter

Overview:
- Upstream stage of deltaStressHart: converts the raw heartbeat sensor pulse into the 6-bit heart-rate word `hart`.
- Clocked by the shared slow tick.
- Counts debounced beat edges over a fixed window of slow ticks and publishes a saturated 6-bit count per window with a one-tick update strobe.
- Detects a flatline (no beats in a window) and re-arms on the next beat.

Parameters:
- WINDOW_TICKS, 60, slow ticks per measurement window (range 2..1023).
- REFRACT_TICKS, 2, ticks after an accepted beat during which further edges are ignored (range 0..15).

Ports:
- slow  input  1  clock, shared slow tick.
- reset  input  1  asynchronous, active-high reset.
- beat  input  1  raw sensor beat signal, asynchronous to slow.
- hart  output  6  heart-rate count of the last completed window; held between updates.
- hart_valid  output  1  one-tick pulse in the cycle hart is updated.
- overflow  output  1  set with an update whose raw count exceeded 63; cleared at the next update.
- flatline  output  1  high while no beat has been seen since the last zero-count window or since reset.

Behaviour:
- Reset (async, active-high): hart=0, hart_valid=0, overflow=0, flatline=1, state=START, all counters 0, synchronizer flops 0.
- Input path:
  - beat passes through a 2-flop synchronizer, then a registered rising-edge detect.
  - An accepted edge reaches the counter 3 ticks after the pin edge.
  - A level held high counts once.
- Refractory:
  - An accepted edge loads a refractory counter with REFRACT_TICKS.
  - While the counter is nonzero, edges are discarded and the counter decrements each tick.
  - With REFRACT_TICKS=0, every edge is accepted.
- FSM:
  - START: window counter idle, no hart_valid.
    - First accepted edge: beat_cnt=1, win_cnt=0, flatline=0, go to MEASURE.
  - MEASURE: win_cnt increments each tick; an accepted edge increments beat_cnt (8-bit, saturating at 255).
    - At win_cnt==WINDOW_TICKS-1 (terminal tick), an edge accepted on that same tick is included in the closing window.
    - Next tick: hart=min(beat_cnt,63); overflow=(beat_cnt>63); hart_valid=1 for exactly one tick.
    - After the update, win_cnt=0 and beat_cnt=0 (or 1 if an edge is accepted on the update tick itself), and MEASURE continues.
    - If the closed window has beat_cnt==0: hart=0, hart_valid pulses, flatline=1, go to START.
- Latency: hart_valid asserts 1 tick after the terminal tick.
- hart never changes except in a hart_valid tick or on reset.
- Reset mid-window: partial count is discarded; no hart_valid is produced.
- Downstream contract: hart is stable for WINDOW_TICKS ticks between updates, which satisfies the 3-sample equality check downstream.

Optional Feature:
- Macro: HART_AVG_EN.
- Defined: the published hart is (cur+prev+1)>>1, computed in 7 bits. cur is the saturated count of the window just closed; prev is the saturated count of the previous published window.
  - prev is cleared on reset and on entry to START.
  - The first window after START publishes cur unaveraged.
  - overflow still reflects the raw cur.
- Undefined: hart=cur. No prev register is synthesized.

Decomposition:
- Package hart_pkg:
  - HART_W=6, HART_MAX=63.
  - State typedef: START, MEASURE.
  - Beat-count width 8.
- Sub-module beat_edge_sync: 2-flop synchronizer, edge detect, refractory counter.
  - Ports: slow, reset, beat, REFRACT_TICKS parameter, output beat_acc (one-tick pulse).
- The top level holds the FSM, window counter, beat counter, and output registers.

Test Plan:
1. Reset, beat=0 for 200 ticks -> state START, hart=0, flatline=1, hart_valid never asserts.
2. beat pulses every 10 ticks (WINDOW_TICKS=60, REFRACT_TICKS=2) -> first hart_valid 61 ticks after the first accepted edge, hart=6, flatline=0, overflow=0; repeats every 60 ticks.
3. beat toggles every tick (edges every 2 ticks), REFRACT_TICKS=2 -> accepted every 4 ticks, hart=15 per window.
4. WINDOW_TICKS=240, REFRACT_TICKS=0, edges every 2 ticks -> raw count 120, hart=63, overflow=1; next window at 1 edge per 8 ticks -> hart=30, overflow=0.
5. Beats stop after one window with hart=6 -> next update hart=0, hart_valid=1, flatline=1, state START; the next beat restarts the window.
6. Reset asserted at win_cnt=30 with beat_cnt=3 -> immediately hart=0, flatline=1, no hart_valid. With HART_AVG_EN: windows of 6 then 10 -> publishes 6 then 8.
